// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding, register index width and counter sizing
package pipeline_hazard_ctrl_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [2:0] {
    INIT   = 3'd0,
    RUN    = 3'd1,
    MULDIV = 3'd2,
    DWAIT  = 3'd3,
    IWAIT  = 3'd4
  } ctrl_state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipe and stall/flush controls back to it
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(parameter int AW = REG_AW);
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [AW-1:0] ex_rd;
  logic          ex_is_load;
  logic          ex_redirect;
  logic          ex_muldiv_start;
  logic          imem_ready;
  logic          dmem_busy;
  logic          pc_we;
  logic          if_id_stall;
  logic          if_id_flush;
  logic          id_ex_bubble;
  logic          ex_hold;
  logic [2:0]    ctrl_state;
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_redirect, ex_muldiv_start, imem_ready, dmem_busy,
    input  pc_we, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, ctrl_state
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_redirect, ex_muldiv_start, imem_ready, dmem_busy,
    output pc_we, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, ctrl_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the EX load destination and the ID sources
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  output logic              load_use
);
  assign load_use = ex_is_load && ex_rd != '0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, redirect, mul/div and memory waits
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(parameter int MULDIV_CYCLES = 4)
(
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hif
);
  localparam int CW = cnt_w(MULDIV_CYCLES);
  ctrl_state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pend, pend_n, load_use, redir;
  logic pc_we, stall, flush, bubble, hold;
  hazard_detect u_hd (
    .id_rs1     (hif.id_rs1),
    .id_rs2     (hif.id_rs2),
    .id_use_rs1 (hif.id_use_rs1),
    .id_use_rs2 (hif.id_use_rs2),
    .ex_rd      (hif.ex_rd),
    .ex_is_load (hif.ex_is_load),
    .load_use   (load_use)
  );
  // a redirect deferred by a data-memory freeze is replayed on the release cycle
  assign redir = hif.ex_redirect || pend;
  // priority-ordered hazard resolution; DWAIT release re-enters the RUN rules with dmem idle
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    pend_n = pend;
    pc_we  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    bubble = 1'b0;
    hold   = 1'b0;
    case (st)
      INIT: begin
        flush  = 1'b1;
        bubble = 1'b1;
        st_n   = RUN;
      end
      MULDIV: begin
        stall = 1'b1;
        hold  = 1'b1;
        st_n  = (cnt == '0) ? RUN : MULDIV;
        cnt_n = (cnt == '0) ? '0 : cnt - 1'b1;
      end
      IWAIT: begin
        pc_we = hif.ex_redirect || hif.imem_ready;
        flush = hif.ex_redirect || !hif.imem_ready;
        st_n  = (hif.ex_redirect || hif.imem_ready) ? RUN : IWAIT;
      end
      default: begin
        if (hif.dmem_busy) begin
          stall  = 1'b1;
          hold   = 1'b1;
          st_n   = DWAIT;
          pend_n = pend || hif.ex_redirect;
        end else if (redir) begin
          pc_we  = 1'b1;
          flush  = 1'b1;
          bubble = 1'b1;
          st_n   = RUN;
          pend_n = 1'b0;
        end else if (hif.ex_muldiv_start && MULDIV_CYCLES > 1) begin
          stall = 1'b1;
          hold  = 1'b1;
          cnt_n = CW'(MULDIV_CYCLES - 2);
          st_n  = MULDIV;
        end else if (load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
          st_n   = RUN;
        end else if (!hif.imem_ready) begin
          flush = 1'b1;
          st_n  = IWAIT;
        end else begin
          pc_we = 1'b1;
          st_n  = RUN;
        end
      end
    endcase
  end
  // only state, mul/div countdown and the pending redirect are registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= INIT;
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      pend <= pend_n;
    end
  end
  assign hif.pc_we        = pc_we;
  assign hif.if_id_stall  = stall;
  assign hif.if_id_flush  = flush;
  assign hif.id_ex_bubble = bubble;
  assign hif.ex_hold      = hold;
  assign hif.ctrl_state   = st;
endmodule
